coin_input_conditioner: RTL

- Front end for the vending-machine controller FSM.
- Takes raw, asynchronous, bouncy nickel and dime pushbutton/coin-switch levels and synchronises and debounces them.
- Emits clean single-cycle `nb`/`db` pulses, one per physical insertion, which feed the FSM's `nb`/`db` inputs directly.
- Guarantees the FSM never sees `nb` and `db` in the same cycle, and flags switches stuck closed.

---
 rtl/coin_input_conditioner_pkg.sv | 23 ++
 rtl/coin_input_conditioner_if.sv | 32 +++
 rtl/coin_input_conditioner_debounce.sv | 117 +++++++++++
 rtl/coin_input_conditioner.sv | 71 +++++++
 4 files changed

// File: rtl/coin_input_conditioner_pkg.sv
`default_nettype none
// ============================================================================
// Module      : coin_pkg
// Description : Shared channel-state encoding and default timing constants
//               for the coin input conditioner.
// Revision    : 1.0 - initial release
// ============================================================================
package coin_pkg;

    localparam int unsigned c_DEBOUNCE_CYCLES = 4;
    localparam int unsigned c_STUCK_CYCLES    = 64;
    localparam int unsigned c_CNT_W           = 7;

    typedef logic [2:0] chan_state_t;

    localparam chan_state_t c_ST_IDLE         = 3'd0;
    localparam chan_state_t c_ST_PRESS_WAIT   = 3'd1;
    localparam chan_state_t c_ST_PRESSED      = 3'd2;
    localparam chan_state_t c_ST_RELEASE_WAIT = 3'd3;
    localparam chan_state_t c_ST_STUCK        = 3'd4;

endpackage : coin_pkg
`default_nettype wire

// File: rtl/coin_input_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module      : coin_input_conditioner_if
// Description : Raw coin switch levels in, clean nb/db pulses and stuck out.
// Revision    : 1.0 - initial release
// ============================================================================
interface coin_input_conditioner_if;

    logic nickel_in;
    logic dime_in;
    logic nb;
    logic db;
    logic stuck;

    modport master (
        output nickel_in,
        output dime_in,
        input  nb,
        input  db,
        input  stuck
    );

    modport slave (
        input  nickel_in,
        input  dime_in,
        output nb,
        output db,
        output stuck
    );

endinterface : coin_input_conditioner_if
`default_nettype wire

// File: rtl/coin_input_conditioner_debounce.sv
`default_nettype none
// ============================================================================
// Module      : coin_debounce_channel
// Description : 2-flop synchroniser, debounce FSM and saturating counter for
//               one coin switch; emits a one-cycle accept per press.
// Revision    : 1.0 - initial release
// ============================================================================
module coin_debounce_channel
    import coin_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES,
    parameter int unsigned STUCK_CYCLES    = c_STUCK_CYCLES,
    parameter int unsigned CNT_W           = c_CNT_W
) (
    input  wire  clk,
    input  wire  rst,
    input  wire  i_raw,
    output logic o_accept,
    output logic o_stuck
);

    localparam logic [CNT_W-1:0] c_DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_STUCK_LAST = CNT_W'(STUCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_ONE        = CNT_W'(1);

    logic [1:0]       r_sync;
    chan_state_t      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_accept;

    chan_state_t      w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_accept_nxt;
    logic             w_sync;

    assign w_sync    = r_sync[1];
    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + c_ONE;

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_accept_nxt = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_sync) begin
                    w_state_nxt = c_ST_PRESS_WAIT;
                    w_cnt_nxt   = c_ONE;
                end
            end
            c_ST_PRESS_WAIT: begin
                if (!w_sync) begin
                    w_state_nxt = c_ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_DEB_LAST) begin
                    w_state_nxt  = c_ST_PRESSED;
                    w_cnt_nxt    = '0;
                    w_accept_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            c_ST_PRESSED: begin
                if (!w_sync) begin
                    w_state_nxt = c_ST_RELEASE_WAIT;
                    w_cnt_nxt   = c_ONE;
                end else if (r_cnt == c_STUCK_LAST) begin
                    w_state_nxt = c_ST_STUCK;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            c_ST_RELEASE_WAIT: begin
                // A bounce back high re-enters PRESSED, so no second accept.
                if (w_sync) begin
                    w_state_nxt = c_ST_PRESSED;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_DEB_LAST) begin
                    w_state_nxt = c_ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            c_ST_STUCK: begin
                if (!w_sync) begin
                    w_state_nxt = c_ST_RELEASE_WAIT;
                    w_cnt_nxt   = c_ONE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync   <= 2'b00;
            r_state  <= c_ST_IDLE;
            r_cnt    <= '0;
            r_accept <= 1'b0;
        end else begin
            r_sync   <= {r_sync[0], i_raw};
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_accept <= w_accept_nxt;
        end
    end

    assign o_accept = r_accept;
    assign o_stuck  = (r_state == c_ST_STUCK);

endmodule : coin_debounce_channel
`default_nettype wire

// File: rtl/coin_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : coin_input_conditioner
// Description : Two debounced coin channels plus arbitration so nb and db
//               never pulse in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module coin_input_conditioner
    import coin_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES,
    parameter int unsigned STUCK_CYCLES    = c_STUCK_CYCLES,
    parameter int unsigned CNT_W           = c_CNT_W
) (
    input wire                     clk,
    input wire                     rst,
    coin_input_conditioner_if.slave bus
);

    logic w_nickel_accept;
    logic w_dime_accept;
    logic w_nickel_stuck;
    logic w_dime_stuck;

    logic r_nb;
    logic r_db;
    logic r_pending;

    coin_debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .STUCK_CYCLES    (STUCK_CYCLES),
        .CNT_W           (CNT_W)
    ) u_nickel (
        .clk      (clk),
        .rst      (rst),
        .i_raw    (bus.nickel_in),
        .o_accept (w_nickel_accept),
        .o_stuck  (w_nickel_stuck)
    );

    coin_debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .STUCK_CYCLES    (STUCK_CYCLES),
        .CNT_W           (CNT_W)
    ) u_dime (
        .clk      (clk),
        .rst      (rst),
        .i_raw    (bus.dime_in),
        .o_accept (w_dime_accept),
        .o_stuck  (w_dime_stuck)
    );

    // Nickel wins a tie; the dime is deferred by exactly one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_nb      <= 1'b0;
            r_db      <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            r_nb      <= w_nickel_accept;
            r_db      <= (w_dime_accept & ~w_nickel_accept) | r_pending;
            r_pending <= w_dime_accept & w_nickel_accept;
        end
    end

    assign bus.nb    = r_nb;
    assign bus.db    = r_db;
    assign bus.stuck = w_nickel_stuck | w_dime_stuck;

endmodule : coin_input_conditioner
`default_nettype wire
